pipe_stage_reg: RTL and testbench

//  Parametrised pipeline-boundary register; successor to the fixed-field, stall-vector-driven stage latches.

---
 rtl/pipe_stage_reg_pkg.sv | 23 ++
 rtl/pipe_stage_reg_entry.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the pipeline-boundary register.
// State encodings and the occupancy decode for pipe_stage_reg.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } ps_state_t;

    function automatic logic [1:0] occ_of(input ps_state_t s);
        logic [1:0] n;
        n = 2'd0;
        unique case (s)
            PS_EMPTY: n = 2'd0;
            PS_FULL:  n = 2'd1;
            PS_SKID:  n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// pipe_entry: one {valid, data, pc, delay} slot.
// Ports: clk, resetn, load, clear, in_* (payload), valid/data/pc/delay (held slot).
import pipe_stage_reg_pkg::*;

module pipe_entry #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_delay,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [PC_W-1:0]   pc,
    output logic              delay
);

    // Clear wins over load so a flush always leaves a zeroed bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
            delay <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
            delay <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            pc    <= in_pc;
            delay <= in_delay;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and back-pressure counter.
// Ports: clk, resetn, flush, in_* (upstream), out_* (downstream), occupancy, bp_cnt.
// Define PIPE_SKID_EN for a registered in_ready and a second (skid) slot.
import pipe_stage_reg_pkg::*;

module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_delay,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_delay,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cnt
);

    ps_state_t state;
    ps_state_t state_nxt;

    logic accept;
    logic consume;
    logic head_load;
    logic head_clear;

    logic [DATA_W-1:0] head_src_data;
    logic [PC_W-1:0]   head_src_pc;
    logic              head_src_delay;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

`ifdef PIPE_SKID_EN
    logic              ready_q;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;
    logic              skid_delay;

    assign in_ready = ready_q;

    // In SKID the head refills from the skid slot, never from upstream.
    assign head_src_data  = (state == PS_SKID) ? skid_data  : in_data;
    assign head_src_pc    = (state == PS_SKID) ? skid_pc    : in_pc;
    assign head_src_delay = (state == PS_SKID) ? skid_delay : in_delay;

    assign head_load = !flush && ((state == PS_SKID) ? consume
                     : (accept && (!out_valid || consume)));

    // Entry arriving while the head is stuck parks in the skid slot.
    assign skid_load  = !flush && accept && out_valid && !consume;
    assign skid_clear = flush || ((state == PS_SKID) && consume);

    pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W)) u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .load     (skid_load),
        .clear    (skid_clear),
        .in_data  (in_data),
        .in_pc    (in_pc),
        .in_delay (in_delay),
        .valid    (skid_valid),
        .data     (skid_data),
        .pc       (skid_pc),
        .delay    (skid_delay)
    );
`else
    assign in_ready       = !out_valid || out_ready;
    assign head_src_data  = in_data;
    assign head_src_pc    = in_pc;
    assign head_src_delay = in_delay;
    assign head_load      = !flush && accept;
`endif

    // Head empties with no replacement: zero it so bubbles trace as pc=0.
    assign head_clear = flush || (consume && !head_load);

    pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W)) u_head (
        .clk      (clk),
        .resetn   (resetn),
        .load     (head_load),
        .clear    (head_clear),
        .in_data  (head_src_data),
        .in_pc    (head_src_pc),
        .in_delay (head_src_delay),
        .valid    (out_valid),
        .data     (out_data),
        .pc       (out_pc),
        .delay    (out_delay)
    );

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = PS_EMPTY;
        end else begin
            unique case (state)
                PS_EMPTY: if (accept) state_nxt = PS_FULL;
                PS_FULL: begin
`ifdef PIPE_SKID_EN
                    if (accept && !consume) state_nxt = PS_SKID;
                    else if (consume && !accept) state_nxt = PS_EMPTY;
`else
                    if (consume && !accept) state_nxt = PS_EMPTY;
`endif
                end
`ifdef PIPE_SKID_EN
                PS_SKID: if (consume) state_nxt = PS_FULL;
`endif
                default: state_nxt = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= PS_EMPTY;
`ifdef PIPE_SKID_EN
            ready_q <= 1'b1;
`endif
        end else begin
            state   <= state_nxt;
`ifdef PIPE_SKID_EN
            ready_q <= (state_nxt != PS_SKID);
`endif
        end
    end

    assign occupancy = occ_of(state);

    // Counts stalled cycles regardless of flush; only reset clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bp_cnt <= '0;
        end else if (out_valid && !out_ready && (bp_cnt != '1)) begin
            bp_cnt <= bp_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Covers reset, streaming, back-pressure, flush, skid ordering and bp_cnt saturation.
module tb_pipe_stage_reg;

    localparam int DATA_W = 16;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic              in_delay;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic              out_delay;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bp_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .in_delay  (in_delay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .out_delay (out_delay),
        .occupancy (occupancy),
        .bp_cnt    (bp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pc     = '0;
        in_delay  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_occ", occupancy, 0);
        check("rst_bp", bp_cnt, 0);
        check("rst_ready", in_ready, 1);

        // 1: async reset while FULL
        in_valid = 1'b1;
        in_pc    = 32'hBFC0_0010;
        in_data  = 16'h1234;
        in_delay = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_pc", out_pc, 64'hBFC0_0010);
        check("t1_data", out_data, 64'h1234);
        check("t1_delay", out_delay, 1);
        tick();
        check("t1_bp", bp_cnt, 1);
        #2 resetn = 1'b0;
        #1;
        check("t1_rst_valid", out_valid, 0);
        check("t1_rst_pc", out_pc, 0);
        check("t1_rst_bp", bp_cnt, 0);
        do_reset();

        // 2: streaming, 1-cycle latency, no gaps
        out_ready = 1'b1;
        in_delay  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h100 + 32'(4 * i);
            in_data  = 16'(i + 1);
            tick();
            check("t2_valid", out_valid, 1);
            check("t2_pc", out_pc, 64'h100 + 64'(4 * i));
            check("t2_data", out_data, 64'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        check("t2_bub_valid", out_valid, 0);
        check("t2_bub_pc", out_pc, 0);
        check("t2_bub_data", out_data, 0);
        check("t2_bp", bp_cnt, 0);

        // 3: back-pressure
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h400;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t3_pc", out_pc, 64'h400);
        check("t3_bp", bp_cnt, 5);
`ifdef PIPE_SKID_EN
        check("t3_ready", in_ready, 1);
`else
        check("t3_ready", in_ready, 0);
`endif
        out_ready = 1'b1;
        #1;
        check("t3_ready_rel", in_ready, 1);
        tick();
        check("t3_drain", out_valid, 0);
        check("t3_bp_hold", bp_cnt, 5);

        // 4: flush drops head and offered entry
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h1FC;
        tick();
        flush = 1'b1;
        in_pc = 32'h200;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_valid", out_valid, 0);
        check("t4_pc", out_pc, 0);
        check("t4_occ", occupancy, 0);
        check("t4_bp", bp_cnt, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no200", out_valid, 0);
        end

        // 5: two offers under back-pressure
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h300;
        tick();
        in_pc = 32'h304;
        tick();
        in_valid = 1'b0;
        check("t5_head", out_pc, 64'h300);
        check("t5_ready", in_ready, 0);
`ifdef PIPE_SKID_EN
        check("t5_occ", occupancy, 2);
        out_ready = 1'b1;
        tick();
        check("t5_second", out_pc, 64'h304);
        check("t5_occ1", occupancy, 1);
        check("t5_ready1", in_ready, 1);
        tick();
        check("t5_empty", out_valid, 0);
`else
        check("t5_occ", occupancy, 1);
        out_ready = 1'b1;
        tick();
        check("t5_empty", out_valid, 0);
        check("t5_occ0", occupancy, 0);
`endif

        // 6: bp_cnt saturation at CNT_W=4
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h500;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t6_bp10", bp_cnt, 10);
        for (int i = 0; i < 10; i++) tick();
        check("t6_sat", bp_cnt, 15);
        tick();
        tick();
        check("t6_hold", bp_cnt, 15);
        check("t6_head", out_pc, 64'h500);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
